// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: op codes, flag bit
// positions and the control FSM state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_NOT   = 4'd6,
        OP_SHL   = 4'd7,
        OP_SHR   = 4'd8,
        OP_ASR   = 4'd9,
        OP_ROR   = 4'd10,
        OP_ROL   = 4'd11,
        OP_SLT   = 4'd12,
        OP_SLTU  = 4'd13,
        OP_MULHU = 4'd14,
        OP_ILL   = 4'd15
    } alu_op_t;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 3;
    localparam int FLG_ERR   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } alu_state_t;

    function automatic logic is_mul_op(alu_op_t op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports: clk, reset (async high), i_start, i_a, i_b -> o_busy, o_done,
// o_prod (2*WIDTH). o_done is high during the final iteration cycle and
// o_prod then shows the value that the final edge will store.
module alu_seq_mul #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   w_sum;

    // r_lo starts as the multiplier and fills with product bits from
    // the top as it shifts right; its LSB selects the next addend.
    assign w_sum  = {1'b0, r_hi}
                  + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign o_prod = {w_sum, r_lo[WIDTH-1:1]};
    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_mcand <= i_a;
            r_hi    <= '0;
            r_lo    <= i_b;
            r_cnt   <= CW'(WIDTH);
        end else if (o_busy) begin
            {r_hi, r_lo} <= o_prod;
            r_cnt        <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-slot ALU stage with valid/ready on both sides and a
// multi-cycle multiplier.
// Ports: clk, reset (async high); in_valid/in_ready, a, b, op on the
// input side; out_valid/out_ready, result, flags {err,ovf,carry,neg,zero}
// on the output side.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    alu_state_t       r_state;
    alu_state_t       w_next;
    logic             r_out_valid;
    logic             r_hi_sel;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_flags;

    alu_op_t          w_op;
    logic             w_accept;
    logic             w_drain;
    logic             w_is_mul;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    logic [SHW-1:0]   w_sh;
    logic [SHW:0]     w_shc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_mul_res;
    logic             w_c;
    logic             w_v;
    logic             w_e;
    logic [4:0]       w_flg;
    logic [4:0]       w_mul_flg;

    assign w_op     = alu_op_t'(op);
    assign w_is_mul = is_mul_op(w_op);

    // in_ready is forced low during reset regardless of register state.
    assign in_ready = !reset && (r_state == IDLE)
                   && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_accept && w_is_mul),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (w_mul_busy),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );

    // Rotates are built from two shifts; w_shc is WIDTH-amount, and a
    // shift by the full WIDTH yields zero so amount 0 returns a unchanged.
    assign w_sh   = b[SHW-1:0];
    assign w_shc  = (SHW+1)'(WIDTH) - {1'b0, w_sh};
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_e   = 1'b0;
        unique case (w_op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1])
                     && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1])
                     && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOT:  w_res = ~a;
            OP_SHL:  w_res = a << w_sh;
            OP_SHR:  w_res = a >> w_sh;
            OP_ASR:  w_res = $signed(a) >>> w_sh;
            OP_ROR:  w_res = (a >> w_sh) | (a << w_shc);
            OP_ROL:  w_res = (a << w_sh) | (a >> w_shc);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}},
                              $signed(a) < $signed(b)};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_ILL:  w_e   = 1'b1;
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_flg            = '0;
        w_flg[FLG_ZERO]  = (w_res == '0);
        w_flg[FLG_NEG]   = w_res[WIDTH-1];
        w_flg[FLG_CARRY] = w_c;
        w_flg[FLG_OVF]   = w_v;
        w_flg[FLG_ERR]   = w_e;
    end

    assign w_mul_res = r_hi_sel ? w_prod[2*WIDTH-1:WIDTH]
                                : w_prod[WIDTH-1:0];

    always_comb begin
        w_mul_flg           = '0;
        w_mul_flg[FLG_ZERO] = (w_mul_res == '0);
        w_mul_flg[FLG_NEG]  = w_mul_res[WIDTH-1];
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept && w_is_mul) w_next = MUL;
            MUL: begin
                if (w_mul_done)      w_next = HOLD;
                else if (!w_mul_busy) w_next = IDLE;
            end
            HOLD: if (!r_out_valid || out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // A new result wins over a drain on the same edge, which is what
    // lets a consumer take one result while the next op is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_hi_sel    <= 1'b0;
        end else begin
            if (w_accept) r_hi_sel <= (w_op == OP_MULHU);
            if (w_accept && !w_is_mul) begin
                r_result    <= w_res;
                r_flags     <= w_flg;
                r_out_valid <= 1'b1;
            end else if ((r_state == MUL) && w_mul_done) begin
                r_result    <= w_mul_res;
                r_flags     <= w_mul_flg;
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised successor to the 64-bit ALU. It is generalised in WIDTH and adds a valid/ready handshake on both sides, an iterative multi-cycle multiplier (low and high product), arithmetic shift, signed/unsigned compare, and status flags. It sits between the operand/decode stage and writeback. Only one operation is in flight at a time, and a single registered output slot holds each result until it is consumed.

Parameters:
WIDTH, 64, operand/result width in bits; must be at least 4.
SHW, $clog2(WIDTH), shift-amount bits. Derived; do not override.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operands and op are presented
in_ready  out  1  block accepts this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B; b[SHW-1:0] is the shift/rotate amount
op  in  4  operation code (alu_pkg::alu_op_t)
out_valid  out  1  result slot full
out_ready  in  1  consumer takes result
result  out  WIDTH  registered result
flags  out  5  {err, ovf, carry, neg, zero}

Behaviour:
- One clock and one reset. Reset is asynchronous and active-high.
- Reset values: in_ready=0 while reset is asserted; after reset, state=IDLE; out_valid=0, result=0, flags=0, multiplier registers cleared.
- Handshake:
  - Transfer occurs when valid and ready are both high at a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). Same-cycle drain and accept is allowed.
  - out_valid stays high, and result/flags stay stable, until out_ready is sampled high.
- Op codes:
  - 0 ADD, 1 SUB (a-b), 2 MUL (low WIDTH bits), 3 AND, 4 OR, 5 XOR, 6 NOT a (b ignored).
  - 7 SHL, 8 SHR logical, 9 ASR, 10 ROR, 11 ROL.
  - 12 SLT signed, 13 SLTU (result is 1 or 0).
  - 14 MULHU (upper WIDTH bits of the unsigned 2*WIDTH product).
  - 15 illegal: result=0, err=1.
- Arithmetic and width rules:
  - ADD and SUB wrap modulo 2^WIDTH.
  - Shift amount is b mod WIDTH (b[SHW-1:0]). An amount of 0 returns a unchanged.
- Flags:
  - zero = (result==0).
  - neg = result[WIDTH-1].
  - carry: carry-out for ADD; borrow (a<b unsigned) for SUB; 0 for all other ops.
  - ovf: signed overflow for ADD and SUB only.
  - err: set only for op 15.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: on accept of a non-MUL op, compute combinationally and register at the accepting edge. out_valid rises after 1 edge (latency 1). Remain in IDLE.
  - IDLE: on accept of MUL or MULHU, latch a, b and op, set count=WIDTH, go to MUL.
  - MUL: one shift-add iteration per cycle, count decrements. The edge that processes the last iteration writes result, sets out_valid and goes to HOLD. Total latency is WIDTH edges after the accepting edge.
  - HOLD: return to IDLE when out_valid && out_ready, or immediately if out_valid is already clear.
- Boundary conditions:
  - in_ready=0 throughout MUL and HOLD. New in_valid is ignored; it is not queued.
  - Output blocked (out_valid=1, out_ready=0): in_ready=0 and nothing is accepted.
  - Reset mid-MUL: the operation is abandoned, out_valid=0, and no partial result is ever emitted.
  - in_valid with in_ready=0: the inputs are not sampled.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_t enum (values 0..15 as listed above);
  - flag bit index localparams FLG_ZERO=0, FLG_NEG=1, FLG_CARRY=2, FLG_OVF=3, FLG_ERR=4;
  - state enum alu_state_t {IDLE, MUL, HOLD}.
- One sub-module, alu_seq_mul (WIDTH parameter). It is an iterative unsigned shift-add multiplier with start/busy/done and a 2*WIDTH product. alu_pipe selects the low or high half.

Test Plan:
- ADD 64'hFFFFFFFFFFFFFFFF + 1 with out_ready=1 -> after 1 edge, result=0, flags zero=1, carry=1, ovf=0. SUB 3-4 -> 64'hFFFFFFFFFFFFFFFF, carry=1, neg=1.
- MUL 3000000*2000000 -> out_valid exactly 64 edges after accept, result=6000000000000. During MUL, in_ready=0; a concurrent in_valid ADD is not taken. MULHU 64'hFFFFFFFFFFFFFFFF*2 -> result=1.
- ROR 1 by 1 -> 64'h8000000000000000. ROL 64'h4000000000000001 by 2 -> 5. ASR 64'h8000000000000000 by 4 -> 64'hF800000000000000. SHL by 65 -> treated as shift by 1.
- Back-pressure: hold out_ready=0 for 5 cycles after an XOR result -> result and flags stable, in_ready=0. Raise out_ready together with a new in_valid -> drain and accept occur on the same edge, and the next result appears 1 edge later.
- Reset asserted asynchronously at iteration 20 of a MUL -> out_valid drops immediately and stays 0. After release, state=IDLE and in_ready=1; op 15 then returns result=0 with err=1.
- WIDTH=8 instance: ADD 127+1 -> 8'h80, ovf=1, neg=1. SLT 8'hFF<1 -> 1 and SLTU -> 0. MUL 15*17 -> 8'hFF after 8 edges.
